// File: rtl/lsu_byte_serializer.sv
// lsu_byte_serializer: turns core byte/half/word loads and stores into
// little-endian byte transactions on a byte-wide, 1-cycle-latency data memory.
// Load data is assembled and sign/zero-extended for writeback.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned requests return a fault
// instead of being force-aligned.
`timescale 1ns/1ps

module lsu_byte_serializer #(
    parameter int ADDR_W   = 32,
    parameter int BASE_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    generate
        if (BASE_LAT != 1) begin : g_bad_latency
            $error("lsu_byte_serializer supports BASE_LAT == 1 only");
        end
    endgenerate

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t      state;
    logic [1:0]  cnt;        // index of the byte currently on the memory bus
    logic        write_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] wdata_q;
    logic [31:0] asm_q;      // load data assembled so far

    logic              req_mis;
    logic [ADDR_W-1:0] req_base;
    logic [1:0]        last_idx;
    logic [1:0]        cap_idx;
    logic [31:0]       asm_fill;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz,
                                           input logic sg);
        case (sz)
            2'd0:    return {{24{sg & v[7]}}, v[7:0]};
            2'd1:    return {{16{sg & v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    // Request decode: misalignment, aligned base address, last byte index,
    // and the assembly word with the byte arriving this cycle merged in.
    always_comb begin
        req_base = req_addr[ADDR_W-1:0];
        req_mis  = 1'b0;
        case (req_size)
            2'd0: req_mis = 1'b0;
            2'd1: begin
                req_mis     = req_addr[0];
                req_base[0] = 1'b0;
            end
            default: begin
                req_mis       = (req_addr[1:0] != 2'b00);
                req_base[1:0] = 2'b00;
            end
        endcase

        case (size_q)
            2'd0:    last_idx = 2'd0;
            2'd1:    last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase

        // mem_rdata lags the strobe by one cycle, so in ISSUE it carries the
        // previous byte; in DRAIN it carries the final byte (cnt stays at last).
        cap_idx  = (state == DRAIN) ? cnt : cnt - 2'd1;
        asm_fill = asm_q;
        asm_fill[{cap_idx, 3'b000} +: 8] = mem_rdata;
    end

    // Access sequencer with registered handshake, memory and response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cnt        <= '0;
            asm_q      <= '0;
            write_q    <= 1'b0;
            size_q     <= '0;
            signed_q   <= 1'b0;
            wdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q   <= req_write;
                        size_q    <= req_size;
                        signed_q  <= req_signed;
                        wdata_q   <= req_wdata;
                        cnt       <= '0;
                        asm_q     <= '0;
                        req_ready <= 1'b0;
                        if (TRAP_EN && req_mis) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state     <= ISSUE;
                            mem_addr  <= req_base;
                            mem_re    <= ~req_write;
                            mem_we    <= req_write;
                            mem_wdata <= req_write ? req_wdata[7:0] : 8'h00;
                        end
                    end
                end
                ISSUE: begin
                    if (!write_q && cnt != 2'd0)
                        asm_q <= asm_fill;
                    if (cnt == last_idx) begin
                        mem_re    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        if (write_q) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        cnt      <= cnt + 2'd1;
                        mem_addr <= mem_addr + ADDR_W'(1);
                        if (write_q)
                            mem_wdata <= byte_of(wdata_q, cnt + 2'd1);
                    end
                end
                DRAIN: begin
                    asm_q      <= asm_fill;
                    resp_rdata <= extend(asm_fill, size_q, signed_q);
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_fault <= 1'b0;
                    resp_rdata <= '0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_byte_serializer.sv
// Bench for lsu_byte_serializer: byte memory model, directed scenarios and
// randomized accesses against a byte-array reference of memory contents.
`timescale 1ns/1ps

module tb_lsu_byte_serializer;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TB_TRAP = 1'b1;
`else
    localparam bit TB_TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [256];
    logic [7:0] shadow [256];
    logic       poke_en = 1'b0;
    logic [7:0] poke_a = 8'h00;
    logic [7:0] poke_d = 8'h00;
    int         both_hi = 0;

    int          lg_j[$];
    logic        lg_re[$];
    logic        lg_we[$];
    logic [31:0] lg_addr[$];
    logic [7:0]  lg_wd[$];

    lsu_byte_serializer #(.ADDR_W(32), .BASE_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Byte memory: synchronous write, one-cycle read latency, bench preload port.
    always @(posedge clk) begin
        if (poke_en) mem[poke_a] <= poke_d;
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
    end

    always @(negedge clk) if (mem_re && mem_we) both_hi++;

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_base(input logic [31:0] a, input logic [1:0] sz);
        return a - (a % 32'(nbytes(sz)));
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg,
                                               input logic [31:0] base);
        logic [31:0] v = 0;
        int n = nbytes(sz);
        for (int k = 0; k < n; k++)
            v = v + (32'(shadow[(int'(base[7:0]) + k) % 256]) << (8 * k));
        if (sg && n == 1 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
        if (sg && n == 2 && v >= 32'd32768) v = v + 32'hFFFF_0000;
        return v;
    endfunction

    function automatic bit strobes_ok(input logic wr, input logic [31:0] base, input int n,
                                      input logic [31:0] wd);
        if (lg_j.size() != n) return 1'b0;
        for (int k = 0; k < n; k++) begin
            if (lg_j[k] != k + 1) return 1'b0;
            if (lg_addr[k] != base + 32'(k)) return 1'b0;
            if (lg_re[k] != !wr || lg_we[k] != wr) return 1'b0;
            if (wr && lg_wd[k] != 8'((wd >> (8 * k)) & 32'hFF)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic poke(input int a, input logic [7:0] v);
        @(negedge clk);
        poke_en = 1'b1; poke_a = 8'(a); poke_d = v;
        shadow[a] = v;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic do_access(input logic wr, input logic [1:0] sz, input logic sg,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output logic [31:0] rd, output logic flt, output int lat,
                             output logic rdy_after);
        lg_j.delete(); lg_re.delete(); lg_we.delete(); lg_addr.delete(); lg_wd.delete();
        rd = '0; flt = 1'b0; lat = -1;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_re || mem_we) begin
                lg_j.push_back(j); lg_re.push_back(mem_re); lg_we.push_back(mem_we);
                lg_addr.push_back(mem_addr); lg_wd.push_back(mem_wdata);
            end
            if (resp_valid) begin
                rd = resp_rdata; flt = resp_fault; lat = j;
                break;
            end
        end
        @(negedge clk);
        rdy_after = req_ready;
    endtask

    task automatic test_reset;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        for (int a = 0; a < 256; a++) poke(a, 8'($urandom));
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b expected 1", req_ready); end
        checks++; if (resp_valid !== 1'b0 || resp_fault !== 1'b0 || resp_rdata !== 32'h0) begin
            failures++; $display("FAIL reset_resp got v=%b f=%b d=%h expected 0 0 00000000", resp_valid, resp_fault, resp_rdata); end
        checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 8'h0) begin
            failures++; $display("FAIL reset_mem got re=%b we=%b a=%h d=%h expected all 0", mem_re, mem_we, mem_addr, mem_wdata); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_load;
        logic [31:0] rd; logic flt, rdy; int lat;
        poke(8, 8'h04); poke(9, 8'h00); poke(10, 8'h00); poke(11, 8'h00);
        do_access(1'b0, 2'd2, 1'b0, 32'd8, 32'h0, rd, flt, lat, rdy);
        checks++; if (rd !== 32'h0000_0004) begin failures++; $display("FAIL lw_data got %h expected 00000004", rd); end
        checks++; if (lat != 6) begin failures++; $display("FAIL lw_latency got %0d expected 6", lat); end
        checks++; if (strobes_ok(1'b0, 32'd8, 4, 32'h0) !== 1'b1) begin failures++; $display("FAIL lw_strobes got %0d strobes expected reads of 8..11 in T+1..T+4", lg_j.size()); end
        checks++; if (flt !== 1'b0 || rdy !== 1'b1) begin failures++; $display("FAIL lw_fault_ready got f=%b rdy=%b expected 0 1", flt, rdy); end
    endtask

    task automatic test_byte_load;
        logic [31:0] rd; logic flt, rdy; int lat;
        poke(16, 8'hAA);
        do_access(1'b0, 2'd0, 1'b1, 32'd16, 32'h0, rd, flt, lat, rdy);
        checks++; if (rd !== 32'hFFFF_FFAA) begin failures++; $display("FAIL lb_data got %h expected ffffffaa", rd); end
        checks++; if (lat != 3) begin failures++; $display("FAIL lb_latency got %0d expected 3", lat); end
        do_access(1'b0, 2'd0, 1'b0, 32'd16, 32'h0, rd, flt, lat, rdy);
        checks++; if (rd !== 32'h0000_00AA) begin failures++; $display("FAIL lbu_data got %h expected 000000aa", rd); end
        checks++; if (lat != 3) begin failures++; $display("FAIL lbu_latency got %0d expected 3", lat); end
    endtask

    task automatic test_half_load;
        logic [31:0] rd; logic flt, rdy; int lat;
        poke(24, 8'hEF); poke(25, 8'hBE);
        do_access(1'b0, 2'd1, 1'b1, 32'd24, 32'h0, rd, flt, lat, rdy);
        checks++; if (rd !== 32'hFFFF_BEEF) begin failures++; $display("FAIL lh_data got %h expected ffffbeef", rd); end
        checks++; if (lat != 4) begin failures++; $display("FAIL lh_latency got %0d expected 4", lat); end
        do_access(1'b0, 2'd1, 1'b0, 32'd24, 32'h0, rd, flt, lat, rdy);
        checks++; if (rd !== 32'h0000_BEEF) begin failures++; $display("FAIL lhu_data got %h expected 0000beef", rd); end
    endtask

    task automatic test_word_store;
        logic [31:0] rd; logic flt, rdy; int lat;
        do_access(1'b1, 2'd2, 1'b0, 32'd32, 32'hDEAD_BEEF, rd, flt, lat, rdy);
        checks++; if (lat != 5) begin failures++; $display("FAIL sw_latency got %0d expected 5", lat); end
        checks++; if (strobes_ok(1'b1, 32'd32, 4, 32'hDEAD_BEEF) !== 1'b1) begin failures++; $display("FAIL sw_strobes got %0d strobes expected writes EF BE AD DE to 32..35", lg_j.size()); end
        checks++; if (rd !== 32'h0 || rdy !== 1'b1) begin failures++; $display("FAIL sw_resp got d=%h rdy=%b expected 00000000 1", rd, rdy); end
        shadow[32] = 8'hEF; shadow[33] = 8'hBE; shadow[34] = 8'hAD; shadow[35] = 8'hDE;
        do_access(1'b0, 2'd3, 1'b0, 32'd32, 32'h0, rd, flt, lat, rdy);
        checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw_readback got %h expected deadbeef", rd); end
    endtask

    task automatic test_misaligned;
        logic [31:0] rd, exp; logic flt, rdy; int lat;
        exp = TB_TRAP ? 32'h0 : model_load(2'd2, 1'b0, 32'd4);
        do_access(1'b0, 2'd2, 1'b0, 32'd6, 32'h0, rd, flt, lat, rdy);
        checks++; if (flt !== TB_TRAP) begin failures++; $display("FAIL mis_fault got %b expected %b", flt, TB_TRAP); end
        checks++; if (rd !== exp) begin failures++; $display("FAIL mis_data got %h expected %h", rd, exp); end
        checks++; if (lat != (TB_TRAP ? 1 : 6)) begin failures++; $display("FAIL mis_latency got %0d expected %0d", lat, TB_TRAP ? 1 : 6); end
        checks++; if (strobes_ok(1'b0, 32'd4, TB_TRAP ? 0 : 4, 32'h0) !== 1'b1) begin failures++; $display("FAIL mis_strobes got %0d strobes", lg_j.size()); end
    endtask

    task automatic test_store_reset;
        bit saw_resp = 1'b0;
        poke(40, 8'h11); poke(41, 8'h22); poke(42, 8'h33); poke(43, 8'h44);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'd40; req_wdata = 32'hA5A6_A7A8;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        // Reset lands just after the edge that writes byte 1, before byte 2 commits.
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 8'h0) begin
            failures++; $display("FAIL abort_outputs got rdy=%b v=%b we=%b re=%b a=%h d=%h expected 1 0 0 0 0 0",
                                 req_ready, resp_valid, mem_we, mem_re, mem_addr, mem_wdata); end
        for (int c = 0; c < 3; c++) begin @(negedge clk); if (resp_valid) saw_resp = 1'b1; end
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin @(negedge clk); if (resp_valid) saw_resp = 1'b1; end
        checks++; if (saw_resp) begin failures++; $display("FAIL abort_no_resp got resp_valid=1 expected none"); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got %b expected 1", req_ready); end
        checks++; if ({mem[40], mem[41], mem[42], mem[43]} !== 32'hA8A7_3344) begin
            failures++; $display("FAIL abort_memory got %h%h%h%h expected a8a73344", mem[40], mem[41], mem[42], mem[43]); end
        shadow[40] = 8'hA8; shadow[41] = 8'hA7;
    endtask

    task automatic test_back_to_back;
        logic        wr_t[3]  = '{1'b0, 1'b1, 1'b1};
        logic [1:0]  sz_t[3]  = '{2'd2, 2'd2, 2'd0};
        logic [31:0] ad_t[3]  = '{32'd8, 32'd48, 32'd52};
        int          gap_t[3] = '{7, 6, 3};
        for (int t = 0; t < 3; t++) begin
            int acc[$];
            @(negedge clk);
            req_write = wr_t[t]; req_size = sz_t[t]; req_signed = 1'b0;
            req_addr = ad_t[t]; req_wdata = 32'h1234_565A; req_valid = 1'b1;
            for (int c = 0; c < 20; c++) begin
                if (c > 0) @(negedge clk);
                if (req_ready) acc.push_back(c);
            end
            req_valid = 1'b0;
            for (int c = 0; c < 20 && !req_ready; c++) @(negedge clk);
            checks++;
            if (acc.size() < 3 || acc[1] - acc[0] != gap_t[t] || acc[2] - acc[1] != gap_t[t]) begin
                failures++;
                $display("FAIL b2b_gap case %0d got %0d accepts (first gap %0d) expected gap %0d", t,
                         acc.size(), acc.size() > 1 ? acc[1] - acc[0] : -1, gap_t[t]);
            end
            if (wr_t[t])
                for (int k = 0; k < nbytes(sz_t[t]); k++)
                    shadow[int'(ad_t[t]) + k] = 8'((32'h1234_565A >> (8 * k)) & 32'hFF);
        end
    endtask

    task automatic test_random;
        int bad = 0;
        for (int i = 0; i < 40; i++) begin
            logic wr, sg, mis, trap, flt, rdy;
            logic [1:0] sz;
            logic [31:0] addr, wd, base, rd, exp_rd;
            int n, lat, exp_lat;
            wr = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            addr = 32'(64 + $urandom_range(0, 59)); wd = $urandom();
            n = nbytes(sz);
            mis = (addr % 32'(n)) != 0;
            trap = TB_TRAP && mis;
            base = model_base(addr, sz);
            exp_rd = (wr || trap) ? 32'h0 : model_load(sz, sg, base);
            exp_lat = trap ? 1 : n + (wr ? 1 : 2);
            do_access(wr, sz, sg, addr, wd, rd, flt, lat, rdy);
            checks++; if (rd !== exp_rd) begin failures++; $display("FAIL rnd_data #%0d got %h expected %h", i, rd, exp_rd); end
            checks++; if (lat != exp_lat || flt !== trap || rdy !== 1'b1) begin
                failures++; $display("FAIL rnd_timing #%0d got lat=%0d f=%b rdy=%b expected %0d %b 1", i, lat, flt, rdy, exp_lat, trap); end
            checks++; if (strobes_ok(wr, base, trap ? 0 : n, wd) !== 1'b1) begin
                failures++; $display("FAIL rnd_strobes #%0d got %0d strobes expected %0d from %h", i, lg_j.size(), trap ? 0 : n, base); end
            if (wr && !trap)
                for (int k = 0; k < n; k++) shadow[int'(base[7:0]) + k] = 8'((wd >> (8 * k)) & 32'hFF);
        end
        for (int a = 0; a < 256; a++) if (mem[a] !== shadow[a]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL mem_image got %0d differing bytes expected 0", bad); end
        checks++; if (both_hi != 0) begin failures++; $display("FAIL strobe_overlap got %0d cycles expected 0", both_hi); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_load();
        test_word_store();
        test_misaligned();
        test_store_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
